decode_stage: RTL and testbench

- Second pipeline stage: consumes the fetched instruction word and its PC, decodes the RV32I fields, and reads the register file.
- Detects load-use hazards and raises the fetch/decode stall lines. Squashes the in-flight instruction on a taken branch.
- Registers the decoded bundle into the ID/EX pipeline register that feeds execute. Contains the architectural 32x32 register file, written from writeback.

---
 rtl/decode_stage_pkg.sv | 40 ++++
 rtl/decode_stage_regfile.sv | 44 ++++
 rtl/decode_stage.sv | 138 +++++++++++++
 tb/tb_decode_stage.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats and the immediate builder.
package decode_stage_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    function automatic logic [31:0] gen_imm(input imm_fmt_e fmt, input logic [31:0] ir);
        logic [31:0] imm;
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{ir[31]}}, ir[31:20]};
            IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_U:   imm = {ir[31:12], 12'b0};
            IMM_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Architectural register file: two combinational read ports with write-through
// bypass, one write port, x0 reads as zero and ignores writes.
module decode_stage_regfile
    import decode_stage_pkg::*;
#(
    parameter int W = XLEN,
    parameter int N = NREG
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [4:0]   rs1,
    input  logic [4:0]   rs2,
    output logic [W-1:0] rs1_val,
    output logic [W-1:0] rs2_val,
    input  logic         we,
    input  logic [4:0]   wr_addr,
    input  logic [W-1:0] wr_data
);

    logic [W-1:0] regs [N];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                regs[i] <= '0;
            end
        end else if (we && wr_addr != 5'd0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Bypass lets decode see a value being written back in the same cycle.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0) begin
            rs1_val = (we && wr_addr == rs1) ? wr_data : regs[rs1];
        end
        if (rs2 != 5'd0) begin
            rs2_val = (we && wr_addr == rs2) ? wr_data : regs[rs2];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: field/immediate/control decode, register read, load-use
// stall generation, branch flush and the ID/EX pipeline register.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir_in,
    input  logic [31:0] npc_in,
    input  logic        branch_sig,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        stallF,
    output logic        stallD,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_rs1_val,
    output logic [31:0] id_rs2_val,
    output logic [31:0] id_imm,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [4:0]  id_rd,
    output logic [6:0]  id_opcode,
    output logic [2:0]  id_funct3,
    output logic        id_funct7b5,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_reg_write
);

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_val, rs2_val;
    imm_fmt_e    imm_fmt;
    logic        rs1_used, rs2_used, supported;
    logic        reg_write, mem_read, mem_write;
    logic        hz, bubble;

    assign opcode = ir_in[6:0];
    assign rd     = ir_in[11:7];
    assign rs1    = ir_in[19:15];
    assign rs2    = ir_in[24:20];

    decode_stage_regfile u_regfile (
        .clk     (clk),
        .reset   (reset),
        .rs1     (rs1),
        .rs2     (rs2),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .we      (wb_we),
        .wr_addr (wb_rd),
        .wr_data (wb_data)
    );

    always_comb begin
        imm_fmt   = IMM_NONE;
        rs1_used  = 1'b0;
        rs2_used  = 1'b0;
        supported = 1'b1;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (opcode)
            OP_IMM, OP_JALR: begin
                imm_fmt = IMM_I; rs1_used = 1'b1; reg_write = 1'b1;
            end
            OP_LOAD: begin
                imm_fmt = IMM_I; rs1_used = 1'b1; reg_write = 1'b1; mem_read = 1'b1;
            end
            OP_STORE: begin
                imm_fmt = IMM_S; rs1_used = 1'b1; rs2_used = 1'b1; mem_write = 1'b1;
            end
            OP_BRANCH: begin
                imm_fmt = IMM_B; rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm_fmt = IMM_U; reg_write = 1'b1;
            end
            OP_JAL: begin
                imm_fmt = IMM_J; reg_write = 1'b1;
            end
            OP_REG: begin
                rs1_used = 1'b1; rs2_used = 1'b1; reg_write = 1'b1;
            end
            default: supported = 1'b0;
        endcase
        if (rd == 5'd0) begin
            reg_write = 1'b0;
        end
    end

    assign hz = ex_mem_read && id_valid && (ex_rd != 5'd0) &&
                ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2));

    // A taken branch discards the decode instruction, so holding fetch is pointless.
    assign stallF = hz && !branch_sig;
    assign stallD = stallF;
    assign bubble = branch_sig || hz || !supported;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_valid     <= 1'b0;
            id_pc        <= '0;
            id_rs1_val   <= '0;
            id_rs2_val   <= '0;
            id_imm       <= '0;
            id_rs1       <= '0;
            id_rs2       <= '0;
            id_rd        <= '0;
            id_opcode    <= '0;
            id_funct3    <= '0;
            id_funct7b5  <= 1'b0;
            id_mem_read  <= 1'b0;
            id_mem_write <= 1'b0;
            id_reg_write <= 1'b0;
        end else begin
            id_valid     <= !bubble;
            id_pc        <= npc_in;
            id_rs1_val   <= rs1_val;
            id_rs2_val   <= rs2_val;
            id_imm       <= gen_imm(imm_fmt, ir_in);
            id_rs1       <= rs1;
            id_rs2       <= rs2;
            id_rd        <= bubble ? 5'd0 : rd;
            id_opcode    <= opcode;
            id_funct3    <= ir_in[14:12];
            id_funct7b5  <= ir_in[30];
            id_mem_read  <= mem_read && !bubble;
            id_mem_write <= mem_write && !bubble;
            id_reg_write <= reg_write && !bubble;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: the driver queues hand-computed expectations,
// a monitor checks stall lines before each edge and the ID/EX bundle after it.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ir_in = '0, npc_in = '0, wb_data = '0;
    logic        branch_sig = 1'b0, ex_mem_read = 1'b0, wb_we = 1'b0;
    logic [4:0]  ex_rd = '0, wb_rd = '0;
    logic        stallF, stallD, id_valid, id_funct7b5;
    logic        id_mem_read, id_mem_write, id_reg_write;
    logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        chk;
        logic        valid;
        logic [31:0] pc, rs1v, rs2v, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7, mr, mw, rw;
    } exp_t;

    exp_t id_q[$];
    logic st_q[$];

    decode_stage dut (
        .clk(clk), .reset(reset), .ir_in(ir_in), .npc_in(npc_in),
        .branch_sig(branch_sig), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stallF(stallF), .stallD(stallD), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_opcode(id_opcode),
        .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write)
    );

    always #5 clk = ~clk;

    function automatic exp_t ins(input logic [31:0] pc, rs1v, rs2v, imm,
                                 input logic [4:0] rs1, rs2, rd, input logic [6:0] op,
                                 input logic [2:0] f3, input logic f7, mr, mw, rw);
        exp_t e;
        e.chk = 1'b1; e.valid = 1'b1; e.pc = pc; e.rs1v = rs1v; e.rs2v = rs2v;
        e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.op = op; e.f3 = f3;
        e.f7 = f7; e.mr = mr; e.mw = mw; e.rw = rw;
        return e;
    endfunction

    function automatic exp_t bub(input logic [31:0] pc);
        exp_t e;
        e = ins(pc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e.chk = 1'b0; e.valid = 1'b0;
        return e;
    endfunction

    task automatic step(input logic [31:0] ir, pc, input logic emr, input logic [4:0] erd,
                        input logic br, we, input logic [4:0] wrd, input logic [31:0] wd,
                        input logic st, input exp_t e);
        @(negedge clk);
        reset = 1'b1;
        ir_in = ir; npc_in = pc; ex_mem_read = emr; ex_rd = erd;
        branch_sig = br; wb_we = we; wb_rd = wrd; wb_data = wd;
        st_q.push_back(st);
        id_q.push_back(e);
    endtask

    task automatic check_reset_state(input string name);
        n_cmp++;
        if (id_valid || stallF || stallD || (|{id_pc, id_rs1_val, id_rs2_val, id_imm, id_rs1,
            id_rs2, id_rd, id_opcode, id_funct3, id_funct7b5, id_mem_read, id_mem_write,
            id_reg_write})) begin
            n_bad++;
            $display("FAIL %s: got valid=%0b stall=%0b%0b pc=%h rs1v=%h imm=%h rd=%0d, required all zero",
                     name, id_valid, stallF, stallD, id_pc, id_rs1_val, id_imm, id_rd);
        end else begin
            $display("ok   %s: ID/EX cleared", name);
        end
    endtask

    // Monitor: stall lines sampled mid-cycle, ID/EX sampled just after the edge.
    initial begin
        exp_t e;
        logic st, ok;
        forever begin
            @(negedge clk);
            #2;
            if (st_q.size() != 0) begin
                st = st_q.pop_front();
                n_cmp++;
                if (stallF !== st || stallD !== st) begin
                    n_bad++;
                    $display("FAIL stall: got stallF=%0b stallD=%0b, required %0b", stallF, stallD, st);
                end else begin
                    $display("ok   stall: %0b", st);
                end
            end
            @(posedge clk);
            #1;
            if (id_q.size() != 0) begin
                e = id_q.pop_front();
                ok = (id_valid === e.valid) && (id_pc === e.pc) && (id_rd === e.rd) &&
                     (id_mem_read === e.mr) && (id_mem_write === e.mw) && (id_reg_write === e.rw);
                if (e.chk) begin
                    ok = ok && (id_rs1_val === e.rs1v) && (id_rs2_val === e.rs2v) &&
                         (id_imm === e.imm) && (id_rs1 === e.rs1) && (id_rs2 === e.rs2) &&
                         (id_opcode === e.op) && (id_funct3 === e.f3) && (id_funct7b5 === e.f7);
                end
                n_cmp++;
                if (!ok) begin
                    n_bad++;
                    $display("FAIL idex pc=%h: got v=%0b pc=%h r1v=%h r2v=%h imm=%h rs=%0d/%0d rd=%0d op=%h f3=%0d f7=%0b mr/mw/rw=%0b%0b%0b; required v=%0b pc=%h r1v=%h r2v=%h imm=%h rs=%0d/%0d rd=%0d op=%h f3=%0d f7=%0b mr/mw/rw=%0b%0b%0b",
                             e.pc, id_valid, id_pc, id_rs1_val, id_rs2_val, id_imm, id_rs1, id_rs2,
                             id_rd, id_opcode, id_funct3, id_funct7b5, id_mem_read, id_mem_write,
                             id_reg_write, e.valid, e.pc, e.rs1v, e.rs2v, e.imm, e.rs1, e.rs2, e.rd,
                             e.op, e.f3, e.f7, e.mr, e.mw, e.rw);
                end else begin
                    $display("ok   idex pc=%h valid=%0b rd=%0d", id_pc, id_valid, id_rd);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b0;
        #2 check_reset_state("reset_initial");

        //   ir            pc          emr erd  br we wrd wd            st  expectation
        step(32'h00500093, 32'h8000, 0, 0, 0, 0, 0, 0, 0,
             ins(32'h8000, 0, 0, 5, 0, 5, 1, 7'h13, 0, 0, 0, 0, 1));
        step(32'h00210233, 32'h8004, 0, 0, 0, 1, 2, 32'hDEADBEEF, 0,
             ins(32'h8004, 32'hDEADBEEF, 32'hDEADBEEF, 0, 2, 2, 4, 7'h33, 0, 0, 0, 0, 1));
        step(32'h00010333, 32'h8008, 0, 0, 0, 0, 0, 0, 0,
             ins(32'h8008, 32'hDEADBEEF, 0, 0, 2, 0, 6, 7'h33, 0, 0, 0, 0, 1));
        step(32'h00318133, 32'h800C, 1, 3, 0, 0, 0, 0, 1, bub(32'h800C));
        step(32'h00318133, 32'h800C, 0, 0, 0, 0, 0, 0, 0,
             ins(32'h800C, 0, 0, 0, 3, 3, 2, 7'h33, 0, 0, 0, 0, 1));
        step(32'h00312423, 32'h8014, 1, 3, 1, 0, 0, 0, 0, bub(32'h8014));
        step(32'h00312423, 32'h8018, 0, 0, 0, 0, 0, 0, 0,
             ins(32'h8018, 32'hDEADBEEF, 0, 8, 2, 3, 8, 7'h23, 2, 0, 0, 1, 0));
        step(32'h00412383, 32'h801C, 0, 0, 0, 0, 0, 0, 0,
             ins(32'h801C, 32'hDEADBEEF, 0, 4, 2, 4, 7, 7'h03, 2, 0, 1, 0, 1));
        step(32'hFE000EE3, 32'h8020, 0, 0, 0, 0, 0, 0, 0,
             ins(32'h8020, 0, 0, 32'hFFFFFFFC, 0, 0, 29, 7'h63, 0, 1, 0, 0, 0));
        step(32'h000180B7, 32'h8024, 1, 3, 0, 0, 0, 0, 0,
             ins(32'h8024, 0, 0, 32'h00018000, 3, 0, 1, 7'h37, 0, 0, 0, 0, 1));
        step(32'h000000B7, 32'h8028, 0, 0, 0, 0, 0, 0, 0,
             ins(32'h8028, 0, 0, 0, 0, 0, 1, 7'h37, 0, 0, 0, 0, 1));
        step(32'h008000EF, 32'h802C, 0, 0, 0, 0, 0, 0, 0,
             ins(32'h802C, 0, 0, 8, 0, 8, 1, 7'h6F, 0, 0, 0, 0, 1));
        step(32'h000004B3, 32'h8030, 0, 0, 0, 1, 0, 7, 0,
             ins(32'h8030, 0, 0, 0, 0, 0, 9, 7'h33, 0, 0, 0, 0, 1));
        step(32'h000004B3, 32'h8034, 0, 0, 0, 0, 0, 0, 0,
             ins(32'h8034, 0, 0, 0, 0, 0, 9, 7'h33, 0, 0, 0, 0, 1));
        step(32'h00000000, 32'h8038, 0, 0, 0, 1, 5, 32'h55, 0, bub(32'h8038));
        step(32'h00028313, 32'h803C, 0, 0, 0, 0, 0, 0, 0,
             ins(32'h803C, 32'h55, 0, 0, 5, 0, 6, 7'h13, 0, 0, 0, 0, 1));
        // Load-use stall pending when reset drops mid-cycle.
        step(32'h00028313, 32'h8040, 1, 5, 0, 0, 0, 0, 1, bub(32'h0));
        #3 reset = 1'b0;
        #1 check_reset_state("reset_midstream");
        step(32'h00028313, 32'h8044, 0, 0, 0, 0, 0, 0, 0,
             ins(32'h8044, 0, 0, 0, 5, 0, 6, 7'h13, 0, 0, 0, 0, 1));

        for (int i = 0; i < 20 && (id_q.size() != 0 || st_q.size() != 0); i++) begin
            @(posedge clk);
        end
        #3;
        if (id_q.size() != 0 || st_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d/%0d pending expectations, required 0/0", id_q.size(), st_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
